// File: rtl/col_buff_writer_if.sv
// Pixel stream and column-buffer FIFO signals seen by the column buffer write controller.
interface col_buff_writer_if #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
);
    logic              i_start;
    logic              i_valid;
    logic [W_DATA-1:0] i_data;
    logic              o_ready;
    logic              i_fifo_full;
    logic              i_fifo_empty;
    logic [W_ADDR:0]   i_occupants;
    logic              o_write_enable;
    logic [W_DATA-1:0] o_write_data;
    logic              o_busy;
    logic              o_frame_done;

    modport slave (
        input  i_start, i_valid, i_data, i_fifo_full, i_fifo_empty, i_occupants,
        output o_ready, o_write_enable, o_write_data, o_busy, o_frame_done
    );

    modport master (
        output i_start, i_valid, i_data, i_fifo_full, i_fifo_empty, i_occupants,
        input  o_ready, o_write_enable, o_write_data, o_busy, o_frame_done
    );
endinterface

// File: rtl/col_buff_writer.sv
// Writes one ROW*COL frame plus a zero terminator into the column FIFO; 1-cycle write latency.
// o_ready drops combinationally on FIFO full or when the in-flight write would overflow.
module col_buff_writer #(
    parameter int COL    = 3,
    parameter int ROW    = 9,
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    col_buff_writer_if.slave   bus
);
    localparam int FRAME = ROW * COL;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int DEPTH = 2 ** W_ADDR;
    localparam logic [CW-1:0]     LAST    = CW'(FRAME - 1);
    localparam logic [W_ADDR+1:0] DEPTH_V = (W_ADDR+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, TERM, DRAIN} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [W_ADDR+1:0]   occ_next;
    logic                space_ok;
    logic                accept;

    // The occupancy input lags our own write by a cycle, so count the strobe in flight.
    assign occ_next     = {1'b0, bus.i_occupants} + {{(W_ADDR+1){1'b0}}, bus.o_write_enable};
    assign space_ok     = occ_next < DEPTH_V;
    assign bus.o_ready  = (state == FILL) && !bus.i_fifo_full && space_ok;
    assign accept       = bus.i_valid && bus.o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.o_write_enable <= 1'b0;
            bus.o_write_data   <= '0;
            bus.o_busy         <= 1'b0;
            bus.o_frame_done   <= 1'b0;
        end else begin
            bus.o_write_enable <= 1'b0;
            bus.o_frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.i_start && bus.i_fifo_empty) begin
                        state      <= FILL;
                        bus.o_busy <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        bus.o_write_enable <= 1'b1;
                        bus.o_write_data   <= bus.i_data;
                        cnt                <= cnt + 1'b1;
                        if (cnt == LAST) state <= TERM;
                    end
                end
                TERM: begin
                    if (!bus.i_fifo_full && space_ok) begin
                        bus.o_write_enable <= 1'b1;
                        bus.o_write_data   <= '0;
                        state              <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The terminator strobe is still in flight on the first DRAIN cycle.
                    if (bus.i_fifo_empty && !bus.o_write_enable) begin
                        bus.o_frame_done <= 1'b1;
                        bus.o_busy       <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_col_buff_writer.sv
// Directed bench for col_buff_writer with a counting FIFO model and a log of every write.
module tb_col_buff_writer;
    localparam int FRAME = 27;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       force_full = 1'b0;
    logic       flush = 1'b0;
    int         occ = 0;
    logic [7:0] log_q[$];
    int         checks = 0;
    int         errors = 0;

    col_buff_writer_if #(.W_DATA(8), .W_ADDR(8)) bus ();

    col_buff_writer #(.COL(3), .ROW(9), .W_DATA(8), .W_ADDR(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    assign bus.i_fifo_full  = force_full || (occ >= 256);
    assign bus.i_fifo_empty = (occ == 0);
    assign bus.i_occupants  = 9'(occ);

    // FIFO model: never drains by itself, emptied only by an explicit flush.
    always @(posedge i_clk) begin
        if (bus.o_write_enable) log_q.push_back(bus.o_write_data);
        occ <= flush ? 0 : occ + int'(bus.o_write_enable);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("busy_rise", bus.o_busy, 1);
        check("ready_fill", bus.o_ready, 1);
    endtask

    // mode 0: continuous, 1: valid toggling, 2: full held 5 cycles after word 10
    task automatic stream(input int mode, input logic [7:0] base, input bit zeros, input int limit);
        int   acc = 0;
        int   cyc = 0;
        int   fcnt = 0;
        logic prev_acc = 1'b0;
        while (acc < limit && cyc < 500) begin
            bus.i_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            bus.i_data  = zeros ? 8'd0 : 8'(base + acc + 1);
            if (mode == 2 && acc == 10 && fcnt < 5) begin
                force_full = 1'b1;
                fcnt++;
            end else begin
                force_full = 1'b0;
            end
            @(negedge i_clk);
            if (force_full) check("bp_ready", bus.o_ready, 0);
            if (force_full && fcnt > 1) check("bp_we", bus.o_write_enable, 0);
            if (mode == 1) check("bub_we", bus.o_write_enable, prev_acc);
            prev_acc = bus.i_valid && bus.o_ready;
            if (prev_acc) acc++;
            tick();
            cyc++;
        end
        bus.i_valid = 1'b0;
        force_full  = 1'b0;
        check("stream_acc", acc, limit);
    endtask

    task automatic verify_log(input logic [7:0] base, input bit zeros);
        check("log_len", log_q.size(), FRAME + 1);
        if (log_q.size() == FRAME + 1) begin
            for (int i = 0; i < FRAME; i++)
                check("log_dat", log_q[i], zeros ? 8'd0 : 8'(base + i + 1));
            check("log_term", log_q[FRAME], 0);
        end
    endtask

    task automatic terminate(input int mode, input logic [7:0] base, input bit zeros);
        check("rdy_last", bus.o_ready, 0);
        check("we_last", bus.o_write_enable, 1);
        if (mode == 2) begin
            force_full = 1'b1;
            repeat (3) begin
                tick();
                check("term_hold_we", bus.o_write_enable, 0);
            end
            force_full = 1'b0;
        end
        tick();
        check("term_we", bus.o_write_enable, 1);
        check("term_dat", bus.o_write_data, 0);
        check("term_busy", bus.o_busy, 1);
        tick();
        check("drain_we", bus.o_write_enable, 0);
        verify_log(base, zeros);
        check("occ_full", occ, FRAME + 1);
    endtask

    task automatic finish_frame(input bit start_in_drain);
        for (int i = 0; i < 20; i++) begin
            bus.i_start = start_in_drain && (i == 5);
            tick();
            check("drain_busy", bus.o_busy, 1);
            check("drain_done", bus.o_frame_done, 0);
            check("drain_ready", bus.o_ready, 0);
        end
        bus.i_start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty_seen_done", bus.o_frame_done, 0);
        tick();
        check("done_pulse", bus.o_frame_done, 1);
        check("busy_fall", bus.o_busy, 0);
        tick();
        check("done_clear", bus.o_frame_done, 0);
        check("idle_busy", bus.o_busy, 0);
        log_q.delete();
    endtask

    initial begin
        i_rst       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'd0;
        repeat (2) tick();
        check("rst_we", bus.o_write_enable, 0);
        check("rst_wd", bus.o_write_data, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_frame_done, 0);
        check("rst_ready", bus.o_ready, 0);
        i_rst = 1'b0;
        tick();

        // Nominal frame 1..27, with an ignored start while draining.
        start_frame();
        stream(0, 8'd0, 1'b0, FRAME);
        terminate(0, 8'd0, 1'b0);
        finish_frame(1'b1);

        // Upstream bubbles.
        start_frame();
        stream(1, 8'd100, 1'b0, FRAME);
        terminate(1, 8'd100, 1'b0);
        finish_frame(1'b0);

        // Backpressure in FILL and in TERM.
        start_frame();
        stream(2, 8'd200, 1'b0, FRAME);
        terminate(2, 8'd200, 1'b0);
        finish_frame(1'b0);

        // Reset after word 12.
        start_frame();
        stream(0, 8'd50, 1'b0, 12);
        i_rst = 1'b1;
        tick();
        check("mrst_we", bus.o_write_enable, 0);
        check("mrst_wd", bus.o_write_data, 0);
        check("mrst_busy", bus.o_busy, 0);
        check("mrst_done", bus.o_frame_done, 0);
        check("mrst_ready", bus.o_ready, 0);
        i_rst = 1'b0;
        repeat (3) tick();
        check("mrst_log", log_q.size(), 12);
        check("mrst_occ", occ, 12);

        // Start is ignored while the FIFO still holds data.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("gate_busy", bus.o_busy, 0);
        check("gate_ready", bus.o_ready, 0);
        tick();
        check("gate_idle", bus.o_busy, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        log_q.delete();

        // Full frame after the abandoned one.
        start_frame();
        stream(0, 8'd60, 1'b0, FRAME);
        terminate(0, 8'd60, 1'b0);
        finish_frame(1'b0);

        // All-zero data frame.
        start_frame();
        stream(0, 8'd0, 1'b1, FRAME);
        terminate(0, 8'd0, 1'b1);
        finish_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
